// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: registered position, sync and strobes.
// Define VGA_LOOKAHEAD_EN to add nextX/nextY/next_in_image outputs.
module vga_timing_gen #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic             PIXEL_CLK,
    input  logic             RST_N,
    input  logic             CE,
    output logic [CNT_W-1:0] locX,
    output logic [CNT_W-1:0] locY,
    output logic             in_image,
    output logic             sync_h,
    output logic             sync_v,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_LOOKAHEAD_EN
    ,
    output logic [CNT_W-1:0] nextX,
    output logic [CNT_W-1:0] nextY,
    output logic             next_in_image
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: porch/sync/active values must be nonzero");
    end
    if (H_TOTAL > (64'd1 << CNT_W) || V_TOTAL > (64'd1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_END_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_END_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ZERO_C  = '0;
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] hx_q, hx_d;
    logic [CNT_W-1:0] vy_q, vy_d;
    logic [CNT_W-1:0] loc_x_q, loc_x_d;
    logic [CNT_W-1:0] loc_y_q, loc_y_d;
    logic             in_image_q, in_image_d;
    logic             sync_h_q, sync_h_d;
    logic             sync_v_q, sync_v_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic cur_in_image;
    logic cur_h_sync;
    logic cur_v_sync;

    // Decode of the position about to be presented on the next CE edge.
    always_comb begin
        cur_in_image = (hx_q < H_ACT_C) && (vy_q < V_ACT_C);
        cur_h_sync   = (hx_q >= H_SS_C) && (hx_q < H_SE_C);
        cur_v_sync   = (vy_q >= V_SS_C) && (vy_q < V_SE_C);
    end

    always_comb begin
        hx_d          = hx_q;
        vy_d          = vy_q;
        loc_x_d       = loc_x_q;
        loc_y_d       = loc_y_q;
        in_image_d    = in_image_q;
        sync_h_d      = sync_h_q;
        sync_v_d      = sync_v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (CE) begin
            loc_x_d       = hx_q;
            loc_y_d       = vy_q;
            in_image_d    = cur_in_image;
            sync_h_d      = cur_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
            sync_v_d      = cur_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
            line_start_d  = (hx_q == ZERO_C);
            frame_start_d = (hx_q == ZERO_C) && (vy_q == ZERO_C);
            if (hx_q == H_END_C) begin
                hx_d = ZERO_C;
                vy_d = (vy_q == V_END_C) ? ZERO_C : vy_q + ONE_C;
            end else begin
                hx_d = hx_q + ONE_C;
            end
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            hx_q          <= '0;
            vy_q          <= '0;
            loc_x_q       <= '0;
            loc_y_q       <= '0;
            in_image_q    <= 1'b0;
            sync_h_q      <= ~H_SYNC_POL;
            sync_v_q      <= ~V_SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hx_q          <= hx_d;
            vy_q          <= vy_d;
            loc_x_q       <= loc_x_d;
            loc_y_q       <= loc_y_d;
            in_image_q    <= in_image_d;
            sync_h_q      <= sync_h_d;
            sync_v_q      <= sync_v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign locX        = loc_x_q;
    assign locY        = loc_y_q;
    assign in_image    = in_image_q;
    assign sync_h      = sync_h_q;
    assign sync_v      = sync_v_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_LOOKAHEAD_EN
    assign nextX         = hx_q;
    assign nextY         = vy_q;
    assign next_in_image = cur_in_image;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a frame-position model.
// Two instances share stimulus: sync polarity 0 and polarity 1.
module tb_vga_timing_gen;

    localparam int CW = 12;
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [CW-1:0] lx0, ly0, lx1, ly1;
    logic          img0, sh0, sv0, ls0, fs0;
    logic          img1, sh1, sv1, ls1, fs1;
`ifdef VGA_LOOKAHEAD_EN
    logic [CW-1:0] nx0, ny0, nx1, ny1;
    logic          ni0, ni1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cnt = 0;
    bit last_ce = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .PIXEL_CLK(clk), .RST_N(rst_n), .CE(ce),
        .locX(lx0), .locY(ly0), .in_image(img0),
        .sync_h(sh0), .sync_v(sv0),
        .line_start(ls0), .frame_start(fs0)
`ifdef VGA_LOOKAHEAD_EN
        , .nextX(nx0), .nextY(ny0), .next_in_image(ni0)
`endif
    );

    vga_timing_gen #(
        .CNT_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_p (
        .PIXEL_CLK(clk), .RST_N(rst_n), .CE(ce),
        .locX(lx1), .locY(ly1), .in_image(img1),
        .sync_h(sh1), .sync_v(sv1),
        .line_start(ls1), .frame_start(fs1)
`ifdef VGA_LOOKAHEAD_EN
        , .nextX(nx1), .nextY(ny1), .next_in_image(ni1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t cnt=%0d)",
                     tag, got, exp, $time, cnt);
        end
    endtask

    // The n-th CE edge since reset shows raster position (n-1) mod FT.
    task automatic check_all();
        int p, x, y;
        bit img, shs, svs, ls, fs;
        x = 0; y = 0; img = 0; shs = 0; svs = 0; ls = 0; fs = 0;
        if (cnt > 0) begin
            p   = (cnt - 1) % FT;
            x   = p % HT;
            y   = p / HT;
            img = (x < 8) && (y < 4);
            shs = (x >= 10) && (x < 13);
            svs = (y >= 5) && (y < 7);
            ls  = last_ce && (x == 0);
            fs  = ls && (y == 0);
        end
        chk("locX", 32'(lx0), 32'(x));
        chk("locY", 32'(ly0), 32'(y));
        chk("in_image", 32'(img0), 32'(img));
        chk("sync_h", 32'(sh0), 32'(!shs));
        chk("sync_v", 32'(sv0), 32'(!svs));
        chk("line_start", 32'(ls0), 32'(ls));
        chk("frame_start", 32'(fs0), 32'(fs));
        chk("locX_p", 32'(lx1), 32'(x));
        chk("sync_h_p", 32'(sh1), 32'(shs));
        chk("sync_v_p", 32'(sv1), 32'(svs));
        chk("frame_start_p", 32'(fs1), 32'(fs));
`ifdef VGA_LOOKAHEAD_EN
        p = cnt % FT;
        chk("nextX", 32'(nx0), 32'(p % HT));
        chk("nextY", 32'(ny0), 32'(p / HT));
        chk("next_in_image", 32'(ni0),
            32'(((p % HT) < 8) && ((p / HT) < 4)));
        chk("nextX_p", 32'(nx1), 32'(p % HT));
`endif
    endtask

    task automatic step(input bit c);
        ce = c;
        @(posedge clk);
        if (c) cnt++;
        last_ce = c;
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        cnt = 0;
        last_ce = 1'b0;
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int fs_n, img_n, svl_n, ls_n, guard;
        ce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        fs_n = 0; img_n = 0; svl_n = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b1);
            fs_n  += int'(fs0);
            img_n += int'(img0);
            svl_n += int'(!sv0);
        end
        chk("frame_start_count", 32'(fs_n), 32'd2);
        chk("in_image_count", 32'(img_n), 32'd64);
        chk("sync_v_low_count", 32'(svl_n), 32'd64);

        ls_n = 0;
        for (int i = 0; i < 3 * 48; i++) begin
            step(i % 3 == 0);
            ls_n += int'(ls0);
        end
        chk("line_start_count", 32'(ls_n), 32'd3);

        guard = 0;
        while (!(cnt > 0 && ((cnt - 1) % FT) == 5 * HT + 11) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        chk("reach_11_5_guard", 32'(guard < 400), 32'd1);
        chk("pre_reset_sync_h", 32'(sh0), 32'd0);
        chk("pre_reset_sync_v", 32'(sv0), 32'd0);
        async_reset();
        step(1'b1);
        chk("restart_frame_start", 32'(fs0), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            step($urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
